// File: rtl/banyan_capture_pkg.sv
// rtl/banyan_capture_pkg.sv - shared types and default widths for the capture sequencer
package banyan_capture_pkg;

    localparam int CW_DEFAULT = 16;
    localparam int NW_DEFAULT = 16;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_DELAY   = 3'd2,
        S_FILL    = 3'd3,
        S_HOLDOFF = 3'd4
    } state_t;

endpackage

// File: rtl/banyan_capture_if.sv
// rtl/banyan_capture_if.sv - host/memory-side signal bundle of the capture sequencer
interface banyan_capture_if #(
    parameter int cw = banyan_capture_pkg::CW_DEFAULT,
    parameter int nw = banyan_capture_pkg::NW_DEFAULT
) ();
    logic          arm;
    logic          abort;
    logic          soft_trig;
    logic          ext_trig;
    logic          mode_ext;
    logic          auto_rearm;
    logic [cw-1:0] trig_delay;
    logic [cw-1:0] holdoff;
    logic          rollover;
    logic          mem_reset;
    logic          mem_run;
    logic [2:0]    state;
    logic          busy;
    logic          done;
    logic [nw-1:0] capture_count;
    logic [nw-1:0] missed_count;

    modport master (
        output arm, abort, soft_trig, ext_trig, mode_ext, auto_rearm,
               trig_delay, holdoff, rollover,
        input  mem_reset, mem_run, state, busy, done, capture_count, missed_count
    );

    modport slave (
        input  arm, abort, soft_trig, ext_trig, mode_ext, auto_rearm,
               trig_delay, holdoff, rollover,
        output mem_reset, mem_run, state, busy, done, capture_count, missed_count
    );
endinterface

// File: rtl/banyan_capture_cnt.sv
// rtl/banyan_capture_cnt.sv - loadable down-counter shared by trigger delay and holdoff
module banyan_capture_cnt
    import banyan_capture_pkg::*;
#(
    parameter int cw = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [cw-1:0] load_val,
    input  logic          dec,
    output logic          one
);
    logic [cw-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && cnt_q != '0) begin
            cnt_q <= cnt_q - cw'(1);
        end
    end

    // Last cycle of a wait: the FSM leaves DELAY/HOLDOFF on this edge.
    assign one = (cnt_q == cw'(1));
endmodule

// File: rtl/banyan_capture_ctl.sv
// rtl/banyan_capture_ctl.sv - arm/trigger/fill/holdoff sequencer for the banyan snapshot memory
module banyan_capture_ctl
    import banyan_capture_pkg::*;
#(
    parameter int cw = CW_DEFAULT,
    parameter int nw = NW_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    banyan_capture_if.slave bus
);
    state_t        state_q, state_d;
    logic          ext_d;
    logic          trg;
    logic          done_q;
    logic          mem_reset_q;
    logic [nw-1:0] cap_q;
    logic [nw-1:0] miss_q;
    logic          cnt_load, cnt_dec, cnt_one;
    logic [cw-1:0] cnt_val;
    logic          set_done, clr_done, inc_cap, inc_miss;

    assign trg = bus.mode_ext ? (bus.ext_trig & ~ext_d) : bus.soft_trig;

    banyan_capture_cnt #(.cw(cw)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .one      (cnt_one)
    );

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_val  = bus.trig_delay;
        cnt_dec  = 1'b0;
        set_done = 1'b0;
        clr_done = 1'b0;
        inc_cap  = 1'b0;
        inc_miss = 1'b0;
        if (bus.abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.arm) begin
                        state_d  = S_ARMED;
                        clr_done = 1'b1;
                    end
                end
                S_ARMED: begin
                    if (trg) begin
                        if (bus.trig_delay == '0) begin
                            state_d = S_FILL;
                        end else begin
                            state_d  = S_DELAY;
                            cnt_load = 1'b1;
                        end
                    end
                end
                S_DELAY: begin
                    cnt_dec  = 1'b1;
                    inc_miss = trg;
                    if (cnt_one) state_d = S_FILL;
                end
                S_FILL: begin
                    inc_miss = trg;
                    if (bus.rollover) begin
                        inc_cap  = 1'b1;
                        set_done = 1'b1;
                        if (!bus.auto_rearm) begin
                            state_d = S_IDLE;
                        end else if (bus.holdoff == '0) begin
                            state_d = S_ARMED;
                        end else begin
                            state_d  = S_HOLDOFF;
                            cnt_load = 1'b1;
                            cnt_val  = bus.holdoff;
                        end
                    end
                end
                S_HOLDOFF: begin
                    cnt_dec  = 1'b1;
                    inc_miss = trg;
                    if (cnt_one) state_d = S_ARMED;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ext_d       <= 1'b0;
            done_q      <= 1'b0;
            mem_reset_q <= 1'b0;
            cap_q       <= '0;
            miss_q      <= '0;
        end else begin
            state_q     <= state_d;
            ext_d       <= bus.ext_trig;
            // Memory reset covers exactly the first FILL cycle, overlapping mem_run.
            mem_reset_q <= (state_d == S_FILL) && (state_q != S_FILL);
            if (clr_done) begin
                done_q <= 1'b0;
            end else if (set_done) begin
                done_q <= 1'b1;
            end
            if (inc_cap) cap_q <= cap_q + nw'(1);
            if (inc_miss && miss_q != '1) miss_q <= miss_q + nw'(1);
        end
    end

    assign bus.mem_reset     = mem_reset_q;
    assign bus.mem_run       = (state_q == S_FILL);
    assign bus.state         = state_q;
    assign bus.busy          = (state_q != S_IDLE);
    assign bus.done          = done_q;
    assign bus.capture_count = cap_q;
    assign bus.missed_count  = miss_q;
endmodule
